adc_ro_framer: RTL and testbench

- Per-channel readout framer that sits directly upstream of a readout FIFO input port (fifo_N_in).
- Accepts ADC samples with a valid strobe and packs two samples per 32-bit word.
- Prefixes each frame with a header word, buffers the words, and drives the FIFO's Avalon-MM write port, obeying waitrequest.
- One instance per ADC channel; the two instances differ only in CH_ID.

---
 rtl/adc_ro_framer.sv | 113 +++++++++++
 tb/tb_adc_ro_framer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adc_ro_framer.sv
// adc_ro_framer: packs ADC samples two per word behind a header word and writes them to an Avalon-MM FIFO port.
// Optional build macro TEST_PATTERN_EN adds test_mode, which swaps adc_data for an internal sample counter.
module adc_ro_framer #(
   parameter int ADC_W = 12,
   parameter int FRAME_WORDS = 8,
   parameter logic [3:0] CH_ID = 4'd0,
   parameter int BUF_DEPTH = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic             enable,
`ifdef TEST_PATTERN_EN
   input  logic             test_mode,
`endif
   input  logic [ADC_W-1:0] adc_data,
   input  logic             adc_valid,
   output logic [31:0]      fifo_writedata,
   output logic             fifo_write,
   input  logic             fifo_waitrequest,
   output logic [15:0]      overflow_count,
   output logic             frame_busy
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(FRAME_WORDS + 1);
   typedef enum logic {IDLE, HDR_DONE} state_t;
   state_t state, state_nx;
   logic [ADC_W-1:0] sample, lo;
   logic half, drop;
   logic [WW-1:0] wcnt;
   logic [15:0] seq;
   logic [31:0] mem [BUF_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic push_hdr, push_dat, push, pop, accept;
   logic [31:0] push_word;
`ifdef TEST_PATTERN_EN
   logic [ADC_W-1:0] tp;
   assign sample = test_mode ? tp : adc_data;
   // pattern counter steps on every strobe and wraps naturally
   always_ff @(posedge clk_clk)
      if (reset_reset) tp <= '0;
      else if (adc_valid) tp <= tp + 1'b1;
`else
   assign sample = adc_data;
`endif
   assign frame_busy = state != IDLE;
   assign push = push_hdr | push_dat;
   assign push_word = push_hdr ? {8'hA5, CH_ID, drop, 3'b000, seq} : {16'(sample), 16'(lo)};
   assign pop = (cnt != '0) && (!fifo_write || !fifo_waitrequest);
   assign accept = push && (!cnt[AW] || pop);
   // frame state register
   always_ff @(posedge clk_clk)
      if (reset_reset) state <= IDLE;
      else state <= state_nx;
   // header on the first sample of a frame, data word on every second sample after it
   always_comb begin
      state_nx = state;
      push_hdr = 1'b0;
      push_dat = 1'b0;
      if (state == IDLE) begin
         push_hdr = adc_valid && enable;
         state_nx = push_hdr ? HDR_DONE : IDLE;
      end else if (adc_valid && half) begin
         push_dat = 1'b1;
         state_nx = (wcnt == WW'(FRAME_WORDS - 1)) ? IDLE : HDR_DONE;
      end
   end
   // sample pairing, word count, sequence number, drop flag and overflow counter
   always_ff @(posedge clk_clk)
      if (reset_reset) begin
         lo <= '0;
         half <= 1'b0;
         wcnt <= '0;
         seq <= '0;
         drop <= 1'b0;
         overflow_count <= '0;
      end else begin
         if (push_hdr) begin
            lo <= sample;
            half <= 1'b1;
            wcnt <= '0;
            seq <= seq + 1'b1;
         end else if (state == HDR_DONE && adc_valid) begin
            if (half) wcnt <= wcnt + 1'b1;
            else lo <= sample;
            half <= ~half;
         end
         if (push_hdr && accept) drop <= 1'b0;
         else if (push && !accept) drop <= 1'b1;
         if (push && !accept && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 1'b1;
      end
   // buffer storage, no reset needed since pointers define the contents
   always_ff @(posedge clk_clk)
      if (accept) mem[wp] <= push_word;
   // buffer pointers and registered Avalon write stage, refilled as a transfer completes
   always_ff @(posedge clk_clk)
      if (reset_reset) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         fifo_write <= 1'b0;
         fifo_writedata <= '0;
      end else begin
         if (accept) wp <= wp + 1'b1;
         if (pop) begin
            rp <= rp + 1'b1;
            fifo_writedata <= mem[rp];
            fifo_write <= 1'b1;
         end else if (!fifo_waitrequest) fifo_write <= 1'b0;
         cnt <= cnt + CW'(accept) - CW'(pop);
      end
endmodule

// File: tb/tb_adc_ro_framer.sv
// tb_adc_ro_framer: table-driven and directed checks of adc_ro_framer with FRAME_WORDS=2, CH_ID=3, BUF_DEPTH=4.
module tb_adc_ro_framer;
   logic clk_clk = 1'b0;
   logic reset_reset, enable, adc_valid, fifo_waitrequest, fifo_write, frame_busy;
   logic [11:0] adc_data;
   logic [31:0] fifo_writedata;
   logic [15:0] overflow_count;
`ifdef TEST_PATTERN_EN
   logic test_mode = 1'b0;
`endif
   int n_pass = 0, n_total = 0;
   logic [31:0] q[$];
   logic [31:0] exp_q[$];
   typedef struct {
      logic v;
      logic [11:0] d;
      logic en;
      logic busy;
   } vec_t;
   vec_t tbl[$];

   adc_ro_framer #(.ADC_W(12), .FRAME_WORDS(2), .CH_ID(4'd3), .BUF_DEPTH(4)) dut (
      .clk_clk(clk_clk),
      .reset_reset(reset_reset),
      .enable(enable),
`ifdef TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .adc_data(adc_data),
      .adc_valid(adc_valid),
      .fifo_writedata(fifo_writedata),
      .fifo_write(fifo_write),
      .fifo_waitrequest(fifo_waitrequest),
      .overflow_count(overflow_count),
      .frame_busy(frame_busy)
   );

   always #5 clk_clk = ~clk_clk;

   always @(negedge clk_clk)
      if (fifo_write && !fifo_waitrequest) q.push_back(fifo_writedata);

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic chk_words(input string nm);
      chk({nm, " count"}, 32'(q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s word%0d", nm, i), (i < q.size()) ? q[i] : 32'hxxxxxxxx, exp_q[i]);
      q.delete();
   endtask

   task automatic do_reset();
      reset_reset = 1'b1;
      adc_valid = 1'b0;
      step();
      step();
      reset_reset = 1'b0;
   endtask

   task automatic sample(input logic [11:0] d);
      adc_valid = 1'b1;
      adc_data = d;
      step();
      adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      adc_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic add(input logic v, input logic [11:0] d, input logic en, input logic busy);
      vec_t r;
      r.v = v;
      r.d = d;
      r.en = en;
      r.busy = busy;
      tbl.push_back(r);
   endtask

   initial begin
      enable = 1'b1;
      adc_data = '0;
      fifo_waitrequest = 1'b0;
      do_reset();
      chk("reset fifo_write", 32'(fifo_write), 0);
      chk("reset writedata", fifo_writedata, 0);
      chk("reset overflow", 32'(overflow_count), 0);
      chk("reset busy", 32'(frame_busy), 0);
      q.delete();

      add(1, 12'h001, 1, 1); add(1, 12'h002, 1, 1); add(1, 12'h003, 1, 1); add(1, 12'h004, 1, 0);
      add(0, 12'h000, 1, 0); add(0, 12'h000, 1, 0); add(0, 12'h000, 1, 0);
      add(1, 12'h005, 1, 1); add(1, 12'h006, 1, 1); add(1, 12'h007, 1, 1); add(1, 12'h008, 1, 0);
      add(0, 12'h000, 1, 0); add(0, 12'h000, 1, 0); add(0, 12'h000, 1, 0);
      add(1, 12'h009, 1, 1); add(1, 12'h00A, 0, 1); add(1, 12'h00B, 0, 1); add(1, 12'h00C, 0, 0);
      add(1, 12'h00D, 0, 0); add(1, 12'h00E, 0, 0);
      add(0, 12'h000, 0, 0); add(0, 12'h000, 0, 0); add(0, 12'h000, 0, 0);
      foreach (tbl[i]) begin
         adc_valid = tbl[i].v;
         adc_data = tbl[i].d;
         enable = tbl[i].en;
         step();
         chk($sformatf("busy row%0d", i), 32'(frame_busy), 32'(tbl[i].busy));
      end
      chk("drained fifo_write", 32'(fifo_write), 0);
      exp_q = '{32'hA5300000, 32'h00020001, 32'h00040003,
                32'hA5300001, 32'h00060005, 32'h00080007,
                32'hA5300002, 32'h000A0009, 32'h000C000B};
      chk_words("frames");

      enable = 1'b1;
      fifo_waitrequest = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         if (c <= 4) sample(12'h010 + 12'(c - 1));
         else idle(1);
         if (c >= 4) begin
            chk($sformatf("hold write c%0d", c), 32'(fifo_write), 1);
            chk($sformatf("hold data c%0d", c), fifo_writedata, 32'hA5300003);
         end
      end
      fifo_waitrequest = 1'b0;
      idle(6);
      exp_q = '{32'hA5300003, 32'h00110010, 32'h00130012};
      chk_words("backpressure");

      do_reset();
      q.delete();
      fifo_waitrequest = 1'b1;
      for (int i = 1; i <= 12; i++) sample(12'(i));
      idle(2);
      chk("overflow count", 32'(overflow_count), 4);
      fifo_waitrequest = 1'b0;
      for (int i = 13; i <= 20; i++) sample(12'(i));
      idle(8);
      chk("overflow hold", 32'(overflow_count), 4);
      exp_q = '{32'hA5300000, 32'h00020001, 32'h00040003, 32'hA5300001, 32'h00060005,
                32'hA5380003, 32'h000E000D, 32'h0010000F,
                32'hA5300004, 32'h00120011, 32'h00140013};
      chk_words("overflow");

      fifo_waitrequest = 1'b1;
      for (int i = 1; i <= 9; i++) sample(12'(i));
      chk("pre-reset fifo_write", 32'(fifo_write), 1);
      chk("pre-reset busy", 32'(frame_busy), 1);
      reset_reset = 1'b1;
      step();
      chk("mid reset fifo_write", 32'(fifo_write), 0);
      chk("mid reset overflow", 32'(overflow_count), 0);
      chk("mid reset busy", 32'(frame_busy), 0);
      reset_reset = 1'b0;
      fifo_waitrequest = 1'b0;
      q.delete();
      for (int i = 1; i <= 4; i++) sample(12'h020 + 12'(i));
      idle(6);
      exp_q = '{32'hA5300000, 32'h00220021, 32'h00240023};
      chk_words("after reset");

`ifdef TEST_PATTERN_EN
      do_reset();
      q.delete();
      test_mode = 1'b1;
      for (int i = 0; i < 4; i++) sample(12'hFFF);
      idle(6);
      test_mode = 1'b0;
      exp_q = '{32'hA5300000, 32'h00010000, 32'h00030002};
      chk_words("test pattern");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
